// File: rtl/two_of_five_pkg.sv
// Shared constants and lookup tables for the 2-of-5 scanned display:
// code weights, 7-segment patterns, 5x7 matrix font and the decoder.
package two_of_five_pkg;

  // Bit i of a code word carries weight WEIGHTS[i]; 4+7 = 11 encodes zero.
  localparam logic [4:0][3:0] WEIGHTS = {4'd7, 4'd4, 4'd2, 4'd1, 4'd0};

  // Glyph index used for an invalid code word.
  localparam logic [3:0] GLYPH_E = 4'd10;

  // Code word loaded at reset: weights 4+7, i.e. the digit '0'.
  localparam logic [4:0] CODE_ZERO = 5'b11000;

  // One 5x7 glyph: element [c] is column c, bit 0 is the top row.
  typedef logic [4:0][6:0] glyph_t;

  // 7-segment table, bit order g..a, active-high.
  function automatic logic [6:0] seg7_of(input logic [3:0] glyph);
    logic [6:0] pat;
    case (glyph)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h79;
    endcase
    return pat;
  endfunction

  // 5x7 font ROM. Literals list column 4 first, column 0 last.
  function automatic glyph_t font_glyph(input logic [3:0] glyph);
    glyph_t g;
    case (glyph)
      4'd0:    g = {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E};
      4'd1:    g = {7'h00, 7'h40, 7'h7F, 7'h42, 7'h00};
      4'd2:    g = {7'h46, 7'h49, 7'h51, 7'h61, 7'h42};
      4'd3:    g = {7'h31, 7'h4B, 7'h45, 7'h41, 7'h21};
      4'd4:    g = {7'h10, 7'h7F, 7'h12, 7'h14, 7'h18};
      4'd5:    g = {7'h39, 7'h45, 7'h45, 7'h45, 7'h27};
      4'd6:    g = {7'h30, 7'h49, 7'h49, 7'h4A, 7'h3C};
      4'd7:    g = {7'h03, 7'h05, 7'h09, 7'h71, 7'h01};
      4'd8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      4'd9:    g = {7'h1E, 7'h29, 7'h49, 7'h49, 7'h06};
      default: g = {7'h41, 7'h49, 7'h49, 7'h49, 7'h7F};
    endcase
    return g;
  endfunction

  // Row data for one column of a glyph; columns beyond 4 read as blank.
  function automatic logic [6:0] font_col(input logic [3:0] glyph, input logic [2:0] col);
    glyph_t g;
    logic [6:0] rows;
    g = font_glyph(glyph);
    case (col)
      3'd0:    rows = g[0];
      3'd1:    rows = g[1];
      3'd2:    rows = g[2];
      3'd3:    rows = g[3];
      3'd4:    rows = g[4];
      default: rows = 7'h00;
    endcase
    return rows;
  endfunction

  // Returns {valid, value}. Valid means exactly two bits set; the weight
  // sum 11 folds to 0. Value is meaningless when valid is 0.
  function automatic logic [4:0] decode_2of5(input logic [4:0] code);
    logic [2:0] ones;
    logic [4:0] sum;
    ones = 3'd0;
    sum  = 5'd0;
    for (int i = 0; i < 5; i++) begin
      if (code[i]) begin
        ones = ones + 3'd1;
        sum  = sum + {1'b0, WEIGHTS[i]};
      end
    end
    return {(ones == 3'd2), (sum == 5'd11) ? 4'd0 : sum[3:0]};
  endfunction

endpackage

// File: rtl/two_of_five_digit_decode.sv
// Combinational decode of one 2-of-5 code word into a validity flag and a
// glyph index (0-9, or the 'E' glyph when the word is malformed).
module two_of_five_digit_decode
  import two_of_five_pkg::*;
(
  input  logic [4:0] code,
  output logic       valid,
  output logic [3:0] glyph
);

  logic [4:0] dec;

  // Map the code word to its glyph, substituting 'E' for invalid words.
  always_comb begin
    dec   = decode_2of5(code);
    valid = dec[4];
    glyph = dec[4] ? dec[3:0] : GLYPH_E;
  end

endmodule

// File: rtl/two_of_five_scan_display.sv
// Time-multiplexed display of NUM_DIGITS 2-of-5 code words on a 7-segment
// bank, plus a column-scanned 5x7 matrix showing the glyph of digit 0.
// Invalid digits show a blinking 'E'. All outputs are registered.
//
// load is a plain capture strobe with no back-pressure: every clk edge that
// sees load=1 copies code_in into the code registers; holding it high simply
// recaptures every cycle and never disturbs the scan.
module two_of_five_scan_display
  import two_of_five_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*NUM_DIGITS-1:0] code_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4:0]              mat_col,
  output logic [6:0]              mat_row,
  output logic [NUM_DIGITS-1:0]   valid_mask,
  output logic                    err
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [2:0]    COL_LAST   = 3'd4;

  logic [5*NUM_DIGITS-1:0] code_reg;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [DW-1:0] digit_idx;
  logic [2:0]    col_idx;
  logic          tick;

  logic [NUM_DIGITS-1:0] dig_valid;
  logic [3:0]            dig_glyph [NUM_DIGITS];

  logic                  sel_valid;
  logic [3:0]            sel_glyph;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [4:0]            col_nxt;
  logic [6:0]            row_nxt;

  assign dp = 1'b0;

  // Capture the code words on load; reset shows '0' on every digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_reg <= {NUM_DIGITS{CODE_ZERO}};
    end else if (load) begin
      code_reg <= code_in;
    end
  end

  // One decoder per captured code word.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    two_of_five_digit_decode u_dec (
      .code  (code_reg[5*k +: 5]),
      .valid (dig_valid[k]),
      .glyph (dig_glyph[k])
    );
  end

  // Scan tick fires on the last count of the prescaler.
  always_comb begin
    tick = (scan_cnt == SCAN_LAST);
  end

  // Prescaler, digit/column scan indices and blink phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_idx   <= '0;
      col_idx     <= '0;
    end else if (tick) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DW'(1);
      col_idx   <= (col_idx == COL_LAST) ? 3'd0 : col_idx + 3'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Next display values from the current scan position and captured data;
  // an invalid digit blanks during blink phase 1 but keeps its anode on.
  always_comb begin
    sel_valid = dig_valid[digit_idx];
    sel_glyph = dig_glyph[digit_idx];
    seg_nxt   = (!sel_valid && blink_phase) ? 7'h00 : seg7_of(sel_glyph);
    sel_nxt   = '1;
    sel_nxt[digit_idx] = 1'b0;
    col_nxt   = 5'b00001 << col_idx;
    row_nxt   = (!dig_valid[0] && blink_phase) ? 7'h00
                                               : font_col(dig_glyph[0], col_idx);
  end

  // Output registers; reset blanks the display and reports all digits valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= 7'h00;
      digit_sel  <= '1;
      mat_col    <= 5'b00000;
      mat_row    <= 7'h00;
      valid_mask <= '1;
      err        <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      digit_sel  <= sel_nxt;
      mat_col    <= col_nxt;
      mat_row    <= row_nxt;
      valid_mask <= dig_valid;
      err        <= ~&dig_valid;
    end
  end

endmodule

// File: tb/tb_two_of_five_scan_display.sv
// Directed bench for two_of_five_scan_display with NUM_DIGITS=4,
// SCAN_DIV=4, BLINK_DIV=3. After each reset release the bench numbers the
// clk edges 1,2,...; scan slot s (s ticks since reset) is shown on edges
// 4s+1..4s+4, digit s mod 4, column s mod 5, blink phase floor(s/3) mod 2.
module tb_two_of_five_scan_display;

  logic        clk;
  logic        rst_n;
  logic [19:0] code_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic [4:0]  mat_col;
  logic [6:0]  mat_row;
  logic [3:0]  valid_mask;
  logic        err;

  int n_checks;
  int n_pass;
  int edge_no;

  // digit3 .. digit0
  localparam logic [19:0] DATA_A = {5'b10010, 5'b01100, 5'b00110, 5'b10001}; // 8 6 3 7
  localparam logic [19:0] DATA_B = {5'b10010, 5'b11100, 5'b00110, 5'b10001}; // 8 E 3 7
  localparam logic [19:0] DATA_C = {5'b10010, 5'b01100, 5'b00110, 5'b00000}; // 8 6 3 E
  localparam logic [19:0] DATA_D = {5'b10010, 5'b01100, 5'b00110, 5'b11000}; // 8 6 3 0

  two_of_five_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLINK_DIV  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .mat_col    (mat_col),
    .mat_row    (mat_row),
    .valid_mask (valid_mask),
    .err        (err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (edge %0d): got %h expected %h", tag, edge_no, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    rst_n   = 1'b0;
    load    = 1'b0;
    code_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  // Advance to the negedge following edge 'target'.
  task automatic adv_to(input int target);
    if (target > edge_no) begin
      repeat (target - edge_no) @(posedge clk);
      @(negedge clk);
      edge_no = target;
    end
  endtask

  // Present data with load=1 so it is captured on edge 'target'.
  task automatic load_at(input int target, input logic [19:0] data);
    adv_to(target - 1);
    code_in = data;
    load    = 1'b1;
    adv_to(target);
    load    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " seg"},        seg,        32'h00);
    chk({tag, " digit_sel"},  digit_sel,  32'hF);
    chk({tag, " mat_col"},    mat_col,    32'h00);
    chk({tag, " mat_row"},    mat_row,    32'h00);
    chk({tag, " valid_mask"}, valid_mask, 32'hF);
    chk({tag, " err"},        err,        32'h0);
    chk({tag, " dp"},         dp,         32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    edge_no  = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    code_in  = '0;

    // Reset values and default scan of '0' on every digit
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n   = 1'b1;
    edge_no = 0;
    adv_to(1);
    chk("t1 sel s0", digit_sel, 32'hE);
    chk("t1 seg s0", seg,       32'h3F);
    chk("t1 col s0", mat_col,   32'h01);
    chk("t1 row s0", mat_row,   32'h3E);
    adv_to(4);
    chk("t1 sel hold", digit_sel, 32'hE);
    adv_to(5);
    chk("t1 sel s1", digit_sel, 32'hD);
    chk("t1 col s1", mat_col,   32'h02);
    chk("t1 row s1", mat_row,   32'h51);
    adv_to(9);
    chk("t1 sel s2", digit_sel, 32'hB);
    chk("t1 row s2", mat_row,   32'h49);
    adv_to(13);
    chk("t1 sel s3", digit_sel, 32'h7);
    chk("t1 seg s3", seg,       32'h3F);
    chk("t1 row s3", mat_row,   32'h45);
    adv_to(17);
    chk("t1 sel s4", digit_sel, 32'hE);
    chk("t1 col s4", mat_col,   32'h10);
    adv_to(21);
    chk("t1 col s5", mat_col,   32'h01);
    chk("t1 mask",   valid_mask, 32'hF);
    chk("t1 err",    err,        32'h0);

    // All-valid load: 7 3 6 8
    do_reset();
    load_at(1, DATA_A);
    chk("t2 seg old", seg, 32'h3F);
    adv_to(2);
    chk("t2 seg d0", seg,     32'h07);
    chk("t2 row d0", mat_row, 32'h01);
    adv_to(5);
    chk("t2 seg d1", seg,     32'h4F);
    chk("t2 row c1", mat_row, 32'h71);
    adv_to(9);
    chk("t2 seg d2", seg,     32'h7D);
    chk("t2 row c2", mat_row, 32'h09);
    adv_to(13);
    chk("t2 seg d3", seg,     32'h7F);
    chk("t2 row c3", mat_row, 32'h05);
    adv_to(17);
    chk("t2 row c4", mat_row,    32'h03);
    chk("t2 mask",   valid_mask, 32'hF);
    chk("t2 err",    err,        32'h0);

    // Invalid digit 2 (three bits set) blinks; others steady
    do_reset();
    load_at(1, DATA_B);
    chk("t3 mask old", valid_mask, 32'hF);
    adv_to(2);
    chk("t3 mask", valid_mask, 32'hB);
    chk("t3 err",  err,        32'h1);
    adv_to(9);
    chk("t3 sel s2",  digit_sel, 32'hB);
    chk("t3 seg s2",  seg,       32'h79);
    adv_to(21);
    chk("t3 seg d1 ph1", seg, 32'h4F);
    adv_to(25);
    chk("t3 seg s6", seg, 32'h79);
    adv_to(41);
    chk("t3 sel s10", digit_sel, 32'hB);
    chk("t3 seg s10", seg,       32'h00);
    chk("t3 row s10", mat_row,   32'h01);
    adv_to(45);
    chk("t3 seg d3 ph1", seg, 32'h7F);
    adv_to(57);
    chk("t3 seg s14", seg, 32'h79);

    // Invalid digit 0 drives the 'E' glyph on the matrix, then recovers
    do_reset();
    load_at(1, DATA_C);
    adv_to(2);
    chk("t4 err",  err,        32'h1);
    chk("t4 mask", valid_mask, 32'hE);
    chk("t4 seg",  seg,        32'h79);
    chk("t4 row",  mat_row,    32'h7F);
    adv_to(13);
    chk("t4 seg d3", seg,     32'h7F);
    chk("t4 col3",   mat_col, 32'h08);
    chk("t4 row blank", mat_row, 32'h00);
    adv_to(17);
    chk("t4 sel d0 ph1", digit_sel, 32'hE);
    chk("t4 seg blank",  seg,       32'h00);
    chk("t4 row blank2", mat_row,   32'h00);
    adv_to(25);
    chk("t4 seg d2", seg,     32'h7D);
    chk("t4 row E1", mat_row, 32'h49);
    load_at(26, DATA_D);
    chk("t4 err still", err, 32'h1);
    adv_to(27);
    chk("t4 err clear",  err,        32'h0);
    chk("t4 mask clear", valid_mask, 32'hF);
    chk("t4 row 0c1",    mat_row,    32'h51);

    // Load on the same edge as a scan tick
    do_reset();
    load_at(4, DATA_A);
    chk("t5 sel pre", digit_sel, 32'hE);
    chk("t5 seg pre", seg,       32'h3F);
    adv_to(5);
    chk("t5 sel new", digit_sel, 32'hD);
    chk("t5 seg new", seg,       32'h4F);

    // Reset mid-scan after invalid data
    do_reset();
    load_at(1, DATA_B);
    adv_to(10);
    chk("t6 sel pre", digit_sel, 32'hB);
    chk("t6 seg pre", seg,       32'h79);
    chk("t6 err pre", err,       32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("t6 rst");
    rst_n   = 1'b1;
    edge_no = 0;
    adv_to(1);
    chk("t6 sel", digit_sel,  32'hE);
    chk("t6 seg", seg,        32'h3F);
    chk("t6 col", mat_col,    32'h01);
    chk("t6 row", mat_row,    32'h3E);
    chk("t6 err", err,        32'h0);
    chk("t6 mask", valid_mask, 32'hF);
    adv_to(9);
    chk("t6 sel s2", digit_sel, 32'hB);
    chk("t6 seg s2", seg,       32'h3F);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
